// File: rtl/div_defs.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_defs;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_ripple_subtractor.sv
// N-bit ripple-borrow subtractor (a - b) built from a chain of full-subtractor cells.
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift/trial-subtract per clock, WIDTH iterations.
module seq_divider
    import div_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output state_t           dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: Start is a level request that is taken on any rising edge where
    // Busy=0; while Busy=1 both Start and the operands are ignored. Done marks the
    // single cycle in which fresh Quotient/Remainder/DivByZero first appear.

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] qw;
    logic [WIDTH-1:0] d_reg;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder is WIDTH+1 bits so the shifted value never overflows.
    assign a_shift = (a_reg << 1) | {{WIDTH{1'b0}}, qw[WIDTH-1]};

    ripple_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a         (a_shift),
        .b         ({1'b0, d_reg}),
        .diff      (diff),
        .borrow_out(borrow)
    );

    assign a_next    = borrow ? a_shift : diff;
    assign q_next    = {qw[WIDTH-2:0], ~borrow};
    assign dbg_state = state;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            a_reg     <= '0;
            qw        <= '0;
            d_reg     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                RUN: begin
                    a_reg <= a_next;
                    qw    <= q_next;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state     <= DONE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        Quotient  <= q_next;
                        Remainder <= a_next[WIDTH-1:0];
                        DivByZero <= 1'b0;
                    end
                end
                default: begin
                    if (Start) begin
                        if (Divisor == '0) begin
                            // Divide by zero skips iteration and reports immediately.
                            state     <= DONE;
                            Done      <= 1'b1;
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                        end else begin
                            state <= RUN;
                            Busy  <= 1'b1;
                            a_reg <= '0;
                            qw    <= Dividend;
                            d_reg <= Divisor;
                            count <= CW'(WIDTH - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-count reference model plus directed vectors.
module tb_seq_divider;
    import div_defs::*;

    localparam int W = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Done     (Done),
        .DivByZero(DivByZero),
        .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request finishes a fixed number of edges later
    // with the result given by plain integer / and %.
    int           m_left = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_z    = 1'b0;
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_r    = '0;
    int           p_dvd  = 0;
    int           p_dvs  = 1;
    logic [W-1:0] p_q    = '0;
    logic [W-1:0] p_r    = '0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_z    = 1'b0;
            m_q    = '0;
            m_r    = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_z    = 1'b0;
                end
            end else if (Start) begin
                p_dvd = int'(Dividend);
                p_dvs = int'(Divisor);
                if (p_dvs == 0) begin
                    m_done = 1'b1;
                    m_q    = '1;
                    m_r    = Dividend;
                    m_z    = 1'b1;
                end else begin
                    p_q    = W'(p_dvd / p_dvs);
                    p_r    = W'(p_dvd % p_dvs);
                    m_left = W;
                end
            end
            m_busy = (m_left > 0);
        end
    end

    // Scoreboard compare: every cycle once reset has been applied
    always @(negedge Clock) begin
        if (cmp_en) begin
            check("busy", 32'(Busy), 32'(m_busy));
            check("done", 32'(Done), 32'(m_done));
            check("quotient", 32'(Quotient), 32'(m_q));
            check("remainder", 32'(Remainder), 32'(m_r));
            check("divbyzero", 32'(DivByZero), 32'(m_z));
            if (Done && !DivByZero) begin
                check("inv_product", 32'(int'(Quotient) * p_dvs + int'(Remainder)), 32'(p_dvd));
                check("inv_rem_lt_div", 32'(int'(Remainder) < p_dvs), 32'd1);
            end
        end
    end

    // Driver tasks
    task automatic start_op(input int dvd, input int dvs);
        @(negedge Clock);
        Dividend = W'(dvd);
        Divisor  = W'(dvs);
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
        check("done_seen", 32'(Done), 32'd1);
    endtask

    task automatic run_op(input string name, input int dvd, input int dvs,
                          input int eq, input int er, input int ez, input int elat);
        int lat;
        start_op(dvd, dvs);
        wait_done(lat);
        check({name, "_q"}, 32'(Quotient), 32'(eq));
        check({name, "_r"}, 32'(Remainder), 32'(er));
        check({name, "_z"}, 32'(DivByZero), 32'(ez));
        check({name, "_lat"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        int lat;
        bit saw_done;
        Reset    = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(negedge Clock);
        check("rst_q", 32'(Quotient), 32'd0);
        check("rst_r", 32'(Remainder), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_z", 32'(DivByZero), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        cmp_en = 1'b1;
        Reset  = 1'b0;

        run_op("d13_3", 13, 3, 4, 1, 0, 4);
        run_op("d15_1", 15, 1, 15, 0, 0, 4);
        run_op("d0_7", 0, 7, 0, 0, 0, 4);
        run_op("d5_9", 5, 9, 0, 5, 0, 4);
        run_op("d15_15", 15, 15, 1, 0, 0, 4);

        run_op("d9_0", 9, 0, 15, 9, 1, 0);
        run_op("d8_2", 8, 2, 4, 0, 0, 4);

        for (int dvd = 0; dvd < 16; dvd++) begin
            for (int dvs = 1; dvs < 16; dvs++) begin
                start_op(dvd, dvs);
                wait_done(lat);
                check("sweep_lat", 32'(lat), 32'd4);
            end
        end

        // Start with new operands during RUN must be ignored
        start_op(12, 5);
        Start    = 1'b1;
        Dividend = 4'd3;
        Divisor  = 4'd1;
        repeat (2) @(negedge Clock);
        Start = 1'b0;
        wait_done(lat);
        check("ign_q", 32'(Quotient), 32'd2);
        check("ign_r", 32'(Remainder), 32'd2);
        check("ign_lat", 32'(lat), 32'd2);

        // Start held high: a new request is taken in the DONE cycle
        @(negedge Clock);
        Dividend = 4'd7;
        Divisor  = 4'd2;
        Start    = 1'b1;
        @(negedge Clock);
        wait_done(lat);
        check("held_q", 32'(Quotient), 32'd3);
        check("held_r", 32'(Remainder), 32'd1);
        Dividend = 4'd10;
        Divisor  = 4'd3;
        @(negedge Clock);
        check("held_busy", 32'(Busy), 32'd1);
        check("held_done", 32'(Done), 32'd0);
        Start = 1'b0;
        wait_done(lat);
        check("held2_q", 32'(Quotient), 32'd3);
        check("held2_r", 32'(Remainder), 32'd1);

        // Reset in the middle of an iteration
        start_op(14, 3);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("mid_busy", 32'(Busy), 32'd0);
        check("mid_done", 32'(Done), 32'd0);
        check("mid_q", 32'(Quotient), 32'd0);
        check("mid_r", 32'(Remainder), 32'd0);
        check("mid_z", 32'(DivByZero), 32'd0);
        Reset    = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge Clock);
            if (Done) saw_done = 1'b1;
        end
        check("mid_no_done", 32'(saw_done), 32'd0);
        run_op("d6_4", 6, 4, 1, 2, 0, 4);

        // Reset and Start on the same edge
        @(negedge Clock);
        Reset    = 1'b1;
        Start    = 1'b1;
        Dividend = 4'd5;
        Divisor  = 4'd1;
        @(negedge Clock);
        check("rs_busy", 32'(Busy), 32'd0);
        check("rs_state", 32'(dbg_state), 32'(IDLE));
        check("rs_q", 32'(Quotient), 32'd0);
        check("rs_r", 32'(Remainder), 32'd0);
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clock);
        check("rs_after_busy", 32'(Busy), 32'd0);
        check("rs_after_done", 32'(Done), 32'd0);

        repeat (2) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider: the inverse operation to the team's ripple-carry adder datapath.
- Accepts a WIDTH-bit dividend and divisor on a Start pulse.
- Produces quotient and remainder after WIDTH iteration cycles, one shift/trial-subtract per cycle.
- Sits beside the adder in the arithmetic lab datapath; driven by switches/keys, outputs to HEX/LEDR.

Parameters:
WIDTH, 4, operand/quotient/remainder bit width (>=2)

Ports:
Clock  input  1  system clock, all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
Dividend  input  WIDTH  unsigned dividend, captured on accepted Start
Divisor  input  WIDTH  unsigned divisor, captured on accepted Start
Quotient  output  WIDTH  registered result, held until next completion
Remainder  output  WIDTH  registered result, held until next completion
Busy  output  1  high while iterating (state RUN)
Done  output  1  one-cycle pulse when results update
DivByZero  output  1  registered flag, set with results when captured divisor was 0

Behaviour:
- Reset (priority over everything, any state including mid-RUN):
  - State goes to IDLE.
  - Quotient, Remainder, Busy, Done and DivByZero all go to 0.
  - Counter and working registers are cleared.
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1.
  - DONE: Busy=0, Done=1, lasts exactly one cycle.
- Start acceptance:
  - Start is accepted when Busy=0 (IDLE or DONE) and Start=1 at a rising edge.
  - It is level-sampled; holding Start high restarts after each completion.
  - Start during RUN is ignored, including any operand changes.
- On an accepted Start with Divisor!=0:
  - Latch A=0 (WIDTH+1 bits), Qw=Dividend, D=Divisor.
  - Set count=WIDTH-1 and go to RUN.
- Each RUN edge performs one iteration:
  - {A,Qw} is shifted left 1.
  - T = A_shifted - {0,D}.
  - If no borrow: A=T, Qw[0]=1; else A unchanged, Qw[0]=0.
  - count decrements; on the edge where count==0, go to DONE.
- On entering DONE:
  - Quotient=Qw_final, Remainder=A_final[WIDTH-1:0], DivByZero=0.
  - The result is visible in the same cycle Done=1.
- Latency: Start sampled at edge 0 -> iterations at edges 1..WIDTH -> Done high for the cycle after edge WIDTH. Total WIDTH+1 edges.
- DONE->IDLE on the next edge unless Start is accepted (then -> RUN, or -> DONE for divide-by-zero).
- Divide by zero (captured Divisor==0):
  - No RUN; next state is DONE directly (Done in the cycle after edge 1).
  - Quotient = all ones, Remainder = Dividend, DivByZero=1.
- Arithmetic: trial subtraction is WIDTH+1 bits wide, so the shifted remainder never overflows.
- Outputs: Quotient/Remainder/DivByZero change only on DONE entry or Reset.
- Invariant at Done (divisor!=0): Dividend == Quotient*Divisor + Remainder, Remainder < Divisor.

Decomposition:
- Shared package/header (div_defs):
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH.
- One sub-module, ripple_subtractor:
  - Parameterised WIDTH+1 ripple-borrow subtractor built from full-subtractor cells.
  - Outputs diff and borrow_out.
  - Used combinationally by the RUN datapath.
- FSM, counter and shift registers live in seq_divider.

Test Plan:
- 13/3 with Start pulsed at edge 0 -> Busy high edges 1..4, Done pulse after edge 4, Quotient=4, Remainder=1, DivByZero=0.
- 15/1 -> Q=15, R=0. 0/7 -> Q=0, R=0. 5/9 -> Q=0, R=5. 15/15 -> Q=1, R=0. Exhaustive 16x15 sweep checks the invariant.
- 9/0 -> Done in the cycle after edge 1, Q=4'hF, R=9, DivByZero=1, Busy never high. Following 8/2 -> Q=4, R=0, DivByZero=0.
- Start 12/5, then during RUN drive Start=1 with 3/1 -> ignored, result Q=2, R=2. Start held high through Done -> new operation accepted in the DONE cycle, Busy high next cycle.
- Reset asserted at edge 2 of a 14/3 divide -> next cycle Busy=0, Done=0, Q=0, R=0, DivByZero=0, no Done pulse. Subsequent 6/4 -> Q=1, R=2 after 5 edges.
- Reset and Start both high on the same edge -> Reset wins, stays IDLE, outputs 0.
